// File: rtl/bp_update_queue.sv
// In-order queue of predicted branches; emits one registered predictor
// update per resolved branch and drops wrong-path entries.
package bp_update_pkg;
    localparam int unsigned VLEN = 32;

    typedef struct packed {
        logic       valid;
        logic       taken;
        logic [9:0] gindex;
        logic [7:0] lindex;
    } bp_metadata_t;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
        bp_metadata_t    metadata;
    } bht_update_t;
endpackage

module bp_update_queue
    import bp_update_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             flush_i,
    input  logic                             debug_mode_i,
    input  logic                             alloc_valid_i,
    output logic                             alloc_ready_o,
    input  logic [VLEN-1:0]                  alloc_pc_i,
    input  logic [$bits(bp_metadata_t)-1:0]  alloc_metadata_i,
    input  logic                             resolve_valid_i,
    input  logic [VLEN-1:0]                  resolve_pc_i,
    input  logic                             resolve_taken_i,
    input  logic                             resolve_mispredict_i,
    output logic [$bits(bht_update_t)-1:0]   bht_update_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o,
    output logic                             pc_mismatch_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [VLEN-1:0] pc;
        bp_metadata_t    md;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    bht_update_t        upd_q, upd_d;
    logic               mm_q, mm_d;

    logic   pop, mispred, push;
    entry_t head_e;

    assign head_e        = mem_q[head_q];
    assign alloc_ready_o = (count_q < CNT_W'(DEPTH));
    assign pop           = resolve_valid_i && (count_q != '0);
    assign mispred       = pop && resolve_mispredict_i;
    assign push          = alloc_valid_i && alloc_ready_o && !flush_i && !mispred;

    always_comb begin
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        upd_d       = upd_q;
        upd_d.valid = 1'b0;
        mm_d        = 1'b0;
        if (pop) begin
            upd_d.valid    = !debug_mode_i;
            upd_d.pc       = head_e.pc;
            upd_d.taken    = resolve_taken_i;
            upd_d.metadata = head_e.md;
            mm_d           = (resolve_pc_i != head_e.pc);
        end
        // Everything younger than the mispredicted branch is wrong-path.
        if (mispred) begin
            tail_d  = head_q + PTR_W'(1);
            count_d = '0;
        end
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            upd_q   <= '0;
            mm_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            upd_q   <= upd_d;
            mm_q    <= mm_d;
            if (push) mem_q[tail_q] <= '{pc: alloc_pc_i,
                                        md: bp_metadata_t'(alloc_metadata_i)};
        end
    end

    assign bht_update_o  = upd_q;
    assign count_o       = count_q;
    assign pc_mismatch_o = mm_q;
endmodule

// File: tb/tb_bp_update_queue.sv
// Directed bench for bp_update_queue; expected updates go through a
// scoreboard queue checked by an independent monitor.
module tb_bp_update_queue;
    import bp_update_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fl = 1'b0, dbg = 1'b0;
    logic         av = 1'b0, rdy;
    logic [31:0]  apc = '0;
    bp_metadata_t amd = '0;
    logic         rv = 1'b0, rt = 1'b0, rm = 1'b0;
    logic [31:0]  rpc = '0;
    logic [$bits(bht_update_t)-1:0] upd_raw;
    bht_update_t  upd;
    logic [3:0]   cnt;
    logic         mm;

    bp_update_queue #(.DEPTH(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl), .debug_mode_i(dbg),
        .alloc_valid_i(av), .alloc_ready_o(rdy), .alloc_pc_i(apc),
        .alloc_metadata_i(amd), .resolve_valid_i(rv), .resolve_pc_i(rpc),
        .resolve_taken_i(rt), .resolve_mispredict_i(rm),
        .bht_update_o(upd_raw), .count_o(cnt), .pc_mismatch_o(mm)
    );

    assign upd = bht_update_t'(upd_raw);

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        bit           full;
        logic         v;
        logic [31:0]  pc;
        logic         t;
        bp_metadata_t md;
        logic         mm;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: compares DUT output against the scoreboard entry due now.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            e = sbq.pop_front();
            chk("missed_update", 64'(e.cyc), 64'(cyc));
        end
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            e = sbq.pop_front();
            chk("upd_valid", 64'(upd.valid), 64'(e.v));
            chk("pc_mismatch", 64'(mm), 64'(e.mm));
            if (e.full) begin
                chk("upd_pc", 64'(upd.pc), 64'(e.pc));
                chk("upd_taken", 64'(upd.taken), 64'(e.t));
                chk("upd_md", 64'(upd.metadata), 64'(e.md));
            end
        end else if (rst_n && (upd.valid || mm)) begin
            chk("unexpected_output", 64'({upd.valid, mm}), 64'(0));
        end
    end

    function automatic bp_metadata_t mk(int g, int l, bit v, bit t);
        bp_metadata_t m;
        m.valid  = v;
        m.taken  = t;
        m.gindex = 10'(g);
        m.lindex = 8'(l);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(logic [31:0] pc, bp_metadata_t md);
        av = 1'b1; apc = pc; amd = md;
        tick();
        av = 1'b0;
    endtask

    task automatic resolve(logic [31:0] pc, logic t, logic mp);
        rv = 1'b1; rpc = pc; rt = t; rm = mp;
        tick();
        rv = 1'b0; rm = 1'b0;
    endtask

    task automatic expect_upd(bit full, logic v, logic [31:0] pc, logic t,
                              bp_metadata_t md, logic m);
        sbq.push_back('{cyc: cyc + 1, full: full, v: v, pc: pc, t: t, md: md, mm: m});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bp_metadata_t m;
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", 64'(cnt), 64'(0));
        chk("rst_ready", 64'(rdy), 64'(1));
        chk("rst_upd", 64'(upd_raw), 64'(0));
        chk("rst_mm", 64'(mm), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single push/resolve
        m = mk(5, 3, 1, 1);
        push(32'h1000, m);
        chk("t1_count1", 64'(cnt), 64'(1));
        expect_upd(1, 1, 32'h1000, 1, m, 0);
        resolve(32'h1000, 1, 0);
        chk("t1_count0", 64'(cnt), 64'(0));

        // 2: fill, overflow push, drain with wrap
        for (int i = 0; i < 8; i++) push(32'h100 + 32'(4 * i), mk(i, 7 - i, 1, i[0]));
        chk("t2_full_count", 64'(cnt), 64'(8));
        chk("t2_full_ready", 64'(rdy), 64'(0));
        push(32'h200, mk(1, 1, 1, 1));
        chk("t2_overflow_count", 64'(cnt), 64'(8));
        for (int i = 0; i < 8; i++) begin
            expect_upd(1, 1, 32'h100 + 32'(4 * i), i[1], mk(i, 7 - i, 1, i[0]), 0);
            resolve(32'h100 + 32'(4 * i), i[1], 0);
        end
        chk("t2_drain_count", 64'(cnt), 64'(0));
        chk("t2_drain_ready", 64'(rdy), 64'(1));

        // 3: mispredict discards younger entries and same-cycle push
        for (int i = 0; i < 4; i++) push(32'h300 + 32'(4 * i), mk(i + 1, i, 0, 1));
        chk("t3_count4", 64'(cnt), 64'(4));
        av = 1'b1; apc = 32'h400; amd = mk(9, 9, 1, 1);
        expect_upd(1, 1, 32'h300, 1, mk(1, 0, 0, 1), 0);
        resolve(32'h300, 1, 1);
        av = 1'b0;
        chk("t3_count0", 64'(cnt), 64'(0));
        expect_upd(0, 0, '0, 0, '0, 0);
        resolve(32'h304, 0, 0);
        chk("t3_empty_count", 64'(cnt), 64'(0));

        // 4: debug mode masks valid only
        dbg = 1'b1;
        m = mk(9, 9, 1, 0);
        push(32'h500, m);
        chk("t4_count1", 64'(cnt), 64'(1));
        expect_upd(1, 0, 32'h500, 1, m, 0);
        resolve(32'h500, 1, 0);
        chk("t4_count0", 64'(cnt), 64'(0));
        dbg = 1'b0;

        // 5: PC mismatch pulse for exactly one cycle
        m = mk(2, 2, 0, 0);
        push(32'h2000, m);
        expect_upd(1, 1, 32'h2000, 0, m, 1);
        resolve(32'h2004, 0, 0);
        expect_upd(0, 0, '0, 0, '0, 0);
        tick();

        // 6: flush with same-cycle resolve and push
        for (int i = 0; i < 3; i++) push(32'h600 + 32'(4 * i), mk(i + 4, 1, 1, 0));
        chk("t6_count3", 64'(cnt), 64'(3));
        fl = 1'b1; av = 1'b1; apc = 32'h700; amd = mk(3, 3, 1, 1);
        expect_upd(1, 1, 32'h600, 0, mk(4, 1, 1, 0), 0);
        resolve(32'h600, 0, 0);
        fl = 1'b0; av = 1'b0;
        chk("t6_count0", 64'(cnt), 64'(0));
        expect_upd(0, 0, '0, 0, '0, 0);
        resolve(32'h604, 1, 0);
        chk("t6_empty_count", 64'(cnt), 64'(0));

        // 7: asynchronous reset mid-operation
        push(32'hA00, mk(1, 2, 1, 1));
        push(32'hA04, mk(3, 4, 1, 1));
        chk("t7_count2", 64'(cnt), 64'(2));
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_count", 64'(cnt), 64'(0));
        chk("t7_rst_pc", 64'(upd.pc), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        expect_upd(0, 0, '0, 0, '0, 0);
        resolve(32'hA00, 1, 0);
        chk("t7_after_count", 64'(cnt), 64'(0));

        tick();
        tick();
        chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
